// File: rtl/lsu_axi_master.sv
// Load/store unit: one EXU request becomes one AXI4-Lite read or write, with lane alignment,
// load extension, misalign/illegal detection and bus-error reporting; result held until WBU accepts it.
module lsu_axi_master #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int STRB_LEN = DATA_LEN / 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [ADDR_LEN-1:0] addr_i,
    input  logic [DATA_LEN-1:0] wdata_i,
    input  logic [2:0]          load_type_i,
    input  logic [2:0]          store_type_i,
    input  logic [4:0]          wreg_i,
    input  logic                wd_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_LEN-1:0] wdata_o,
    output logic [4:0]          wreg_o,
    output logic                wd_o,
    output logic                misalign_o,
    output logic                err_o,
    output logic [ADDR_LEN-1:0] ar_addr_o,
    output logic                ar_valid_o,
    input  logic                ar_ready_i,
    input  logic [DATA_LEN-1:0] r_data_i,
    input  logic [1:0]          r_resp_i,
    input  logic                r_valid_i,
    output logic                r_ready_o,
    output logic [ADDR_LEN-1:0] aw_addr_o,
    output logic                aw_valid_o,
    input  logic                aw_ready_i,
    output logic [DATA_LEN-1:0] w_data_o,
    output logic [STRB_LEN-1:0] w_strb_o,
    output logic                w_valid_o,
    input  logic                w_ready_i,
    input  logic [1:0]          b_resp_i,
    input  logic                b_valid_i,
    output logic                b_ready_o
);

    localparam int OFF_W = $clog2(STRB_LEN);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_LEN-1:0]   addr_q, addr_d;
    logic [DATA_LEN-1:0]   w_data_q, w_data_d;
    logic [STRB_LEN-1:0]   w_strb_q, w_strb_d;
    logic [2:0]            load_type_q, load_type_d;
    logic                  is_load_q, is_load_d;
    logic                  is_store_q, is_store_d;
    logic [4:0]            wreg_q, wreg_d;
    logic                  wd_q, wd_d;
    logic [DATA_LEN-1:0]   res_q, res_d;
    logic                  misalign_q, misalign_d;
    logic                  err_q, err_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;

    logic                  req_load, req_store, req_legal, req_mis;
    logic [3:0]            req_size;
    logic [OFF_W-1:0]      req_off;
    logic [DATA_LEN-1:0]   r_shift, r_ext;
    logic                  aw_hs, w_hs;

    // Request decode; a nonzero load code takes priority over the store code.
    always_comb begin
        req_load  = (load_type_i != 3'd0);
        req_store = !req_load && (store_type_i != 3'd0);
        req_size  = 4'd0;
        req_legal = 1'b1;
        req_off   = addr_i[OFF_W-1:0];
        if (req_load) begin
            case (load_type_i)
                3'd1, 3'd4: req_size = 4'd1;
                3'd2, 3'd5: req_size = 4'd2;
                3'd3:       req_size = 4'd4;
                3'd6: begin req_size = 4'd4; req_legal = (DATA_LEN == 64); end
                default: begin req_size = 4'd8; req_legal = (DATA_LEN == 64); end
            endcase
        end else if (req_store) begin
            case (store_type_i)
                3'd1: req_size = 4'd1;
                3'd2: req_size = 4'd2;
                3'd3: req_size = 4'd4;
                3'd4: begin req_size = 4'd8; req_legal = (DATA_LEN == 64); end
                default: req_legal = 1'b0;
            endcase
        end
        req_mis = (req_load || req_store) &&
                  (!req_legal || ((req_off & OFF_W'(req_size - 4'd1)) != '0));
    end

    // Load lane extraction and extension
    always_comb begin
        r_shift = r_data_i >> {addr_q[OFF_W-1:0], 3'b000};
        case (load_type_q)
            3'd1:       r_ext = DATA_LEN'($signed(r_shift[7:0]));
            3'd2:       r_ext = DATA_LEN'($signed(r_shift[15:0]));
            3'd3:       r_ext = DATA_LEN'($signed(r_shift[31:0]));
            3'd4:       r_ext = DATA_LEN'(r_shift[7:0]);
            3'd5:       r_ext = DATA_LEN'(r_shift[15:0]);
            3'd6:       r_ext = DATA_LEN'(r_shift[31:0]);
            default:    r_ext = r_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            load_type_q <= '0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            wreg_q      <= '0;
            wd_q        <= 1'b0;
            res_q       <= '0;
            misalign_q  <= 1'b0;
            err_q       <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            load_type_q <= load_type_d;
            is_load_q   <= is_load_d;
            is_store_q  <= is_store_d;
            wreg_q      <= wreg_d;
            wd_q        <= wd_d;
            res_q       <= res_d;
            misalign_q  <= misalign_d;
            err_q       <= err_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    assign aw_hs = aw_valid_o && aw_ready_i;
    assign w_hs  = w_valid_o && w_ready_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid_i) state_d = (!(req_load || req_store) || req_mis) ? DONE : ADDR;
            ADDR: begin
                if (is_load_q) begin
                    if (ar_ready_i) state_d = RESP;
                end else if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = RESP;
                end
            end
            RESP: if ((is_load_q && r_valid_i) || (is_store_q && b_valid_i)) state_d = DONE;
            default: if (out_ready_i) state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        load_type_d = load_type_q;
        is_load_d   = is_load_q;
        is_store_d  = is_store_q;
        wreg_d      = wreg_q;
        wd_d        = wd_q;
        res_d       = res_q;
        misalign_d  = misalign_q;
        err_d       = err_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                addr_d      = addr_i;
                w_data_d    = wdata_i << {req_off, 3'b000};
                w_strb_d    = STRB_LEN'((9'd1 << req_size) - 9'd1) << req_off;
                load_type_d = load_type_i;
                is_load_d   = req_load;
                is_store_d  = req_store;
                wreg_d      = wreg_i;
                misalign_d  = req_mis;
                err_d       = 1'b0;
                aw_done_d   = 1'b0;
                w_done_d    = 1'b0;
                res_d       = '0;
                wd_d        = 1'b0;
                if (!req_mis && !req_load && !req_store) begin
                    res_d = DATA_LEN'(addr_i);
                    wd_d  = wd_i;
                end else if (!req_mis && req_load) begin
                    wd_d  = wd_i;
                end
            end
            ADDR: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
            end
            RESP: begin
                if (is_load_q && r_valid_i) begin
                    err_d = (r_resp_i != 2'b00);
                    res_d = err_d ? '0 : r_ext;
                    if (err_d) wd_d = 1'b0;
                end else if (is_store_q && b_valid_i) begin
                    err_d = (b_resp_i != 2'b00);
                    res_d = '0;
                    wd_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == IDLE);
        ar_valid_o  = (state_q == ADDR) && is_load_q;
        aw_valid_o  = (state_q == ADDR) && is_store_q && !aw_done_q;
        w_valid_o   = (state_q == ADDR) && is_store_q && !w_done_q;
        r_ready_o   = (state_q == RESP) && is_load_q;
        b_ready_o   = (state_q == RESP) && is_store_q;
        out_valid_o = (state_q == DONE);
    end

    assign ar_addr_o  = addr_q;
    assign aw_addr_o  = addr_q;
    assign w_data_o   = w_data_q;
    assign w_strb_o   = w_strb_q;
    assign wdata_o    = res_q;
    assign wreg_o     = wreg_q;
    assign wd_o       = wd_q;
    assign misalign_o = misalign_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: 32-bit instance for the main paths, 64-bit instance for wide lanes.
module tb_lsu_axi_master;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // 32-bit instance signals
    logic        in_valid, in_ready, out_valid, out_ready, wd, wd_o, misalign, err;
    logic [31:0] addr, wdata, wdata_o, ar_addr, aw_addr, r_data, w_data;
    logic [2:0]  load_type, store_type;
    logic [4:0]  wreg, wreg_o;
    logic        ar_valid, ar_ready, r_valid, r_ready, aw_valid, aw_ready, w_valid, w_ready;
    logic        b_valid, b_ready;
    logic [1:0]  r_resp, b_resp;
    logic [3:0]  w_strb;

    // 64-bit instance signals
    logic        in_valid64, in_ready64, out_valid64, out_ready64, wd64, wd_o64, misalign64, err64;
    logic [31:0] addr64, ar_addr64, aw_addr64;
    logic [63:0] wdata64, wdata_o64, r_data64, w_data64;
    logic [2:0]  load_type64, store_type64;
    logic [4:0]  wreg64, wreg_o64;
    logic        ar_valid64, ar_ready64, r_valid64, r_ready64, aw_valid64, aw_ready64;
    logic        w_valid64, w_ready64, b_valid64, b_ready64;
    logic [1:0]  r_resp64, b_resp64;
    logic [7:0]  w_strb64;

    lsu_axi_master #(.DATA_LEN(32), .ADDR_LEN(32)) dut32 (
        .clk(clk), .rstn(rstn),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .addr_i(addr), .wdata_i(wdata),
        .load_type_i(load_type), .store_type_i(store_type), .wreg_i(wreg), .wd_i(wd),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .wdata_o(wdata_o), .wreg_o(wreg_o),
        .wd_o(wd_o), .misalign_o(misalign), .err_o(err),
        .ar_addr_o(ar_addr), .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
        .r_data_i(r_data), .r_resp_i(r_resp), .r_valid_i(r_valid), .r_ready_o(r_ready),
        .aw_addr_o(aw_addr), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
        .w_data_o(w_data), .w_strb_o(w_strb), .w_valid_o(w_valid), .w_ready_i(w_ready),
        .b_resp_i(b_resp), .b_valid_i(b_valid), .b_ready_o(b_ready)
    );

    lsu_axi_master #(.DATA_LEN(64), .ADDR_LEN(32)) dut64 (
        .clk(clk), .rstn(rstn),
        .in_valid_i(in_valid64), .in_ready_o(in_ready64), .addr_i(addr64), .wdata_i(wdata64),
        .load_type_i(load_type64), .store_type_i(store_type64), .wreg_i(wreg64), .wd_i(wd64),
        .out_valid_o(out_valid64), .out_ready_i(out_ready64), .wdata_o(wdata_o64), .wreg_o(wreg_o64),
        .wd_o(wd_o64), .misalign_o(misalign64), .err_o(err64),
        .ar_addr_o(ar_addr64), .ar_valid_o(ar_valid64), .ar_ready_i(ar_ready64),
        .r_data_i(r_data64), .r_resp_i(r_resp64), .r_valid_i(r_valid64), .r_ready_o(r_ready64),
        .aw_addr_o(aw_addr64), .aw_valid_o(aw_valid64), .aw_ready_i(aw_ready64),
        .w_data_o(w_data64), .w_strb_o(w_strb64), .w_valid_o(w_valid64), .w_ready_i(w_ready64),
        .b_resp_i(b_resp64), .b_valid_i(b_valid64), .b_ready_o(b_ready64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] lt,
                         input logic [2:0] st, input logic [4:0] rg, input logic w);
        check("in_ready_before_issue", in_ready, 1'b1);
        in_valid = 1'b1; addr = a; wdata = d; load_type = lt; store_type = st; wreg = rg; wd = w;
        step();
        in_valid = 1'b0;
    endtask

    // Zero-wait AR and R; leaves the bench in the first DONE cycle.
    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] lt,
                           input logic [31:0] rd, input logic [1:0] rsp,
                           input logic [31:0] exp_res, input logic exp_err);
        issue(a, 32'h0, lt, 3'd0, 5'd3, 1'b1);
        check({tag, "_ar_valid"}, ar_valid, 1'b1);
        check({tag, "_ar_addr"}, ar_addr, a);
        ar_ready = 1'b1;
        step();
        ar_ready = 1'b0;
        check({tag, "_resp_state"}, {ar_valid, r_ready, out_valid}, 3'b010);
        r_valid = 1'b1; r_data = rd; r_resp = rsp;
        step();
        r_valid = 1'b0;
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_wdata"}, wdata_o, exp_res);
        check({tag, "_err_wd"}, {err, wd_o, misalign}, {exp_err, !exp_err, 1'b0});
    endtask

    task automatic ld64(input string tag, input logic [2:0] lt, input logic [63:0] exp_res);
        in_valid64 = 1'b1; addr64 = 32'h8000_0004; load_type64 = lt; store_type64 = 3'd0; wd64 = 1'b1;
        step();
        in_valid64 = 1'b0;
        check({tag, "_ar"}, {ar_valid64, ar_addr64}, {1'b1, 32'h8000_0004});
        step();
        step();
        check({tag, "_data"}, {out_valid64, wdata_o64}, {1'b1, exp_res});
        step();
    endtask

    initial begin
        rstn = 1'b0;
        {in_valid, out_ready, wd, ar_ready, r_valid, aw_ready, w_ready, b_valid} = '0;
        {addr, wdata, r_data, load_type, store_type, wreg, r_resp, b_resp} = '0;
        {in_valid64, out_ready64, wd64, ar_ready64, r_valid64, aw_ready64, w_ready64, b_valid64} = '0;
        {addr64, wdata64, r_data64, load_type64, store_type64, wreg64, r_resp64, b_resp64} = '0;
        repeat (2) step();
        check("rst_in_ready", {in_ready, in_ready64}, 2'b11);
        check("rst_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready, out_valid, err, misalign}, 8'h00);
        check("rst_regs", {ar_addr, w_strb, wdata_o}, 68'h0);
        check("rst_valids64", {ar_valid64, aw_valid64, w_valid64, r_ready64, b_ready64,
                               out_valid64, err64, misalign64, wreg_o64, wd_o64, w_strb64}, 22'h0);
        rstn = 1'b1;
        step();

        // Non-memory op: result one cycle after accept
        out_ready = 1'b1;
        issue(32'h0000_1234, 32'h0, 3'd0, 3'd0, 5'd5, 1'b1);
        check("nop_out", {out_valid, wdata_o, wd_o, wreg_o}, {1'b1, 32'h0000_1234, 1'b1, 5'd5});
        check("nop_no_axi", {ar_valid, aw_valid, w_valid, misalign, err}, 5'b0);
        step();
        check("nop_back_idle", {out_valid, in_ready}, 2'b01);

        do_load("lb", 32'h8000_0003, 3'd1, 32'h80AA_BBCC, 2'b00, 32'hFFFF_FF80, 1'b0); step();
        do_load("lbu", 32'h8000_0003, 3'd4, 32'h80AA_BBCC, 2'b00, 32'h0000_0080, 1'b0); step();
        do_load("lh", 32'h8000_0002, 3'd2, 32'h80AA_BBCC, 2'b00, 32'hFFFF_80AA, 1'b0); step();
        do_load("lhu", 32'h8000_0002, 3'd5, 32'h80AA_BBCC, 2'b00, 32'h0000_80AA, 1'b0); step();
        do_load("lw", 32'h8000_0000, 3'd3, 32'h80AA_BBCC, 2'b00, 32'h80AA_BBCC, 1'b0); step();

        // SH: aw_ready two cycles ahead of w_ready
        issue(32'h8000_0002, 32'h0000_BEEF, 3'd0, 3'd2, 5'd7, 1'b1);
        check("sh_lanes", {aw_valid, w_valid, aw_addr, w_data, w_strb},
              {2'b11, 32'h8000_0002, 32'hBEEF_0000, 4'b1100});
        aw_ready = 1'b1;
        step();
        aw_ready = 1'b0;
        check("sh_aw_dropped", {aw_valid, w_valid, b_ready}, 3'b010);
        step();
        check("sh_w_held", {w_valid, w_data, w_strb}, {1'b1, 32'hBEEF_0000, 4'b1100});
        w_ready = 1'b1;
        step();
        w_ready = 1'b0;
        check("sh_resp_state", {aw_valid, w_valid, b_ready, out_valid}, 4'b0010);
        b_valid = 1'b1; b_resp = 2'b00;
        step();
        b_valid = 1'b0;
        check("sh_done", {out_valid, wd_o, wdata_o, err}, {1'b1, 1'b0, 32'h0, 1'b0});
        step();

        // SB: W handshake before AW
        issue(32'h8000_0001, 32'h0000_00A5, 3'd0, 3'd1, 5'd1, 1'b1);
        check("sb_lanes", {w_data, w_strb}, {32'h0000_A500, 4'b0010});
        w_ready = 1'b1;
        step();
        w_ready = 1'b0;
        check("sb_w_first", {aw_valid, w_valid, b_ready}, 3'b100);
        aw_ready = 1'b1;
        step();
        aw_ready = 1'b0;
        check("sb_resp", {aw_valid, w_valid, b_ready}, 3'b001);
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("sb_done", out_valid, 1'b1);
        step();

        // SW: both handshakes in one cycle, slave error on B
        issue(32'h8000_0010, 32'hCAFE_F00D, 3'd0, 3'd3, 5'd2, 1'b1);
        check("sw_lanes", {w_data, w_strb}, {32'hCAFE_F00D, 4'hF});
        aw_ready = 1'b1; w_ready = 1'b1;
        step();
        aw_ready = 1'b0; w_ready = 1'b0;
        check("sw_resp", {aw_valid, w_valid, b_ready}, 3'b001);
        b_valid = 1'b1; b_resp = 2'b11;
        step();
        b_valid = 1'b0; b_resp = 2'b00;
        check("sw_err", {out_valid, err, wd_o}, 3'b110);
        step();

        // Misaligned and illegal-for-32-bit codes: straight to DONE, no AXI
        issue(32'h8000_0002, 32'h0, 3'd3, 3'd0, 5'd4, 1'b1);
        check("lw_mis", {out_valid, misalign, wd_o, wdata_o, ar_valid}, {3'b110, 32'h0, 1'b0});
        step();
        issue(32'h8000_0000, 32'h0, 3'd7, 3'd0, 5'd4, 1'b1);
        check("ld32_illegal", {out_valid, misalign, wd_o, ar_valid}, 4'b1100);
        step();
        issue(32'h8000_0000, 32'h0, 3'd0, 3'd4, 5'd4, 1'b1);
        check("sd32_illegal", {out_valid, misalign, aw_valid, w_valid}, 4'b1100);
        step();

        // Bus error with WBU backpressure for 4 cycles
        out_ready = 1'b0;
        do_load("lw_err", 32'h8000_0004, 3'd3, 32'h1234_5678, 2'b10, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("err_hold", {out_valid, err, wd_o, wdata_o, in_ready}, {3'b110, 32'h0, 1'b0});
            step();
        end
        out_ready = 1'b1;
        step();
        check("err_release", {in_ready, out_valid, err}, 3'b101);

        // Reset while AR is pending
        issue(32'h8000_0008, 32'h0, 3'd3, 3'd0, 5'd6, 1'b1);
        check("rst_mid_ar", ar_valid, 1'b1);
        rstn = 1'b0;
        step();
        check("rst_mid_after", {ar_valid, in_ready, out_valid}, 3'b010);
        rstn = 1'b1;
        step();

        // 64-bit bus
        out_ready64 = 1'b1;
        in_valid64 = 1'b1; addr64 = 32'h8000_0004; store_type64 = 3'd4; load_type64 = 3'd0;
        step();
        in_valid64 = 1'b0;
        check("sd64_mis", {out_valid64, misalign64, aw_valid64, w_valid64, wd_o64}, 5'b11000);
        step();
        ar_ready64 = 1'b1; r_valid64 = 1'b1; r_data64 = 64'h8765_4321_0000_0000;
        ld64("lwu64", 3'd6, 64'h0000_0000_8765_4321);
        ld64("lw64", 3'd3, 64'hFFFF_FFFF_8765_4321);
        ar_ready64 = 1'b0; r_valid64 = 1'b0;
        in_valid64 = 1'b1; addr64 = 32'h8000_0004; store_type64 = 3'd3; load_type64 = 3'd0;
        wdata64 = 64'h0000_0000_DEAD_BEEF;
        step();
        in_valid64 = 1'b0;
        check("sw64_lanes", {aw_valid64, w_data64, w_strb64}, {1'b1, 64'hDEAD_BEEF_0000_0000, 8'hF0});
        aw_ready64 = 1'b1; w_ready64 = 1'b1; b_valid64 = 1'b1;
        step();
        step();
        check("sw64_done", {out_valid64, wd_o64, err64}, 3'b100);
        step();
        in_valid64 = 1'b1; addr64 = 32'h8000_0008; store_type64 = 3'd4;
        wdata64 = 64'h1122_3344_5566_7788;
        step();
        in_valid64 = 1'b0;
        check("sd64_lanes", {w_valid64, w_data64, w_strb64}, {1'b1, 64'h1122_3344_5566_7788, 8'hFF});
        step();
        step();
        check("sd64_done", {out_valid64, misalign64}, 2'b10);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- Parametrised next-generation load/store unit between EXU and WBU.
- Accepts one memory request per valid/ready handshake and issues it as a single AXI4-Lite read or write.
- Aligns sub-word data onto the correct byte lanes, sign/zero-extends loads, and detects misaligned accesses and bus errors.
- Presents the result to writeback through a valid/ready handshake that supports backpressure.
- Supports bus widths of 32 and 64 bits.

Parameters:
- DATA_LEN, 32, data bus and register width; legal values are 32 and 64.
- ADDR_LEN, 32, address width.
- STRB_LEN, DATA_LEN/8, number of byte strobes (derived; do not override).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- in_valid_i  in  1  request valid from EXU
- in_ready_o  out  1  LSU can accept a request
- addr_i  in  ADDR_LEN  effective address, or ALU result for non-memory ops
- wdata_i  in  DATA_LEN  store data, right-aligned
- load_type_i  in  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110 LWU (64-bit only), 111 LD (64-bit only)
- store_type_i  in  3  000 none, 001 SB, 010 SH, 011 SW, 100 SD (64-bit only)
- wreg_i  in  5  destination register
- wd_i  in  1  register write enable
- out_valid_o  out  1  result valid to WBU
- out_ready_i  in  1  WBU accepts the result
- wdata_o  out  DATA_LEN  writeback data
- wreg_o  out  5  registered copy of wreg_i
- wd_o  out  1  effective write enable
- misalign_o  out  1  misaligned access; qualified by out_valid_o
- err_o  out  1  bus error response; qualified by out_valid_o
- AR channel: ar_addr_o out ADDR_LEN; ar_valid_o out 1; ar_ready_i in 1
- R channel: r_data_i in DATA_LEN; r_resp_i in 2; r_valid_i in 1; r_ready_o out 1
- AW channel: aw_addr_o out ADDR_LEN; aw_valid_o out 1; aw_ready_i in 1
- W channel: w_data_o out DATA_LEN; w_strb_o out STRB_LEN; w_valid_o out 1; w_ready_i in 1
- B channel: b_resp_i in 2; b_valid_i in 1; b_ready_o out 1

Behaviour:
- States: IDLE, ADDR, RESP, DONE.
- in_ready_o is 1 only in IDLE. A request is accepted when in_valid_i and in_ready_o are both 1; all request inputs are latched at that edge.
- Access size: 1, 2, 4 or 8 bytes, from the type code.
- off = addr low log2(STRB_LEN) bits. The access is misaligned when off is not a multiple of the access size.
- A request with load_type = 000 and store_type = 000 is a non-memory op:
  - IDLE -> DONE.
  - wdata_o = latched addr_i.
  - out_valid_o rises one cycle after accept.
- A misaligned request:
  - IDLE -> DONE, with no AXI activity.
  - misalign_o = 1, wd_o = 0, wdata_o = 0.
- A load:
  - IDLE -> ADDR; ar_valid_o = 1 and ar_addr_o = the unmodified address.
  - On the AR handshake, ADDR -> RESP.
  - In RESP, r_ready_o = 1. On the R handshake, capture the data and go RESP -> DONE.
  - Data handling: shift r_data right by 8*off, truncate to the access size, then sign-extend (LB, LH, LW) or zero-extend (LBU, LHU, LWU).
- A store:
  - IDLE -> ADDR.
  - w_data_o = wdata shifted left by 8*off.
  - w_strb_o = ((1 << size) - 1) << off.
  - aw_valid_o and w_valid_o rise together. Each drops independently after its own handshake, tracked by internal aw_done and w_done flags.
  - ADDR -> RESP once both handshakes have completed; they may complete in the same cycle or in either order.
  - In RESP, b_ready_o = 1. On the B handshake, RESP -> DONE; wdata_o = 0 and wd_o = 0.
- Any resp != 2'b00:
  - err_o = 1, wd_o = 0, wdata_o = 0.
  - The LSU still returns to IDLE normally.
- DONE:
  - out_valid_o = 1, and all outputs are held stable until out_ready_i = 1.
  - Then DONE -> IDLE; the next request can be accepted at the earliest one cycle later.
- Minimum latencies:
  - Non-memory op: accept to out_valid_o is 1 cycle.
  - Load with zero-wait slave: 3 cycles (ADDR, RESP, DONE).
- AXI rule: a valid, once asserted, stays high with its address/data/strobe stable until the corresponding handshake.
- Illegal codes: LWU, LD or SD with DATA_LEN = 32 are treated as misaligned/illegal (misalign_o = 1, no AXI activity).
- Reset, when rstn = 0 at a clock edge:
  - state = IDLE.
  - All valids and readies = 0, except in_ready_o = 1 after reset.
  - Address/data/strobe registers = 0; out_valid_o, err_o, misalign_o = 0; aw_done = w_done = 0.
- Reset in the middle of a transaction abandons it; the slave is reset in the same cycle.

Test Plan:
- Non-memory op: addr_i = 0x0000_1234, wd_i = 1, wreg_i = 5, out_ready_i = 1 -> out_valid_o one cycle later, wdata_o = 0x1234, wd_o = 1, wreg_o = 5, no AXI valids.
- LB at 0x8000_0003, r_data = 0x80AA_BBCC, zero-wait slave -> ar_addr_o = 0x8000_0003, wdata_o = 0xFFFF_FF80; repeat as LBU -> 0x0000_0080.
- SH at 0x8000_0002, wdata_i = 0x0000_BEEF, slave asserts aw_ready two cycles before w_ready -> w_data_o = 0xBEEF_0000, w_strb_o = 4'b1100, one B handshake, out_valid_o after b_valid.
- LW at 0x8000_0002 -> misalign_o = 1, wd_o = 0, ar_valid_o never asserted; repeat with DATA_LEN = 64 and SD at 0x...4 -> misalign_o = 1.
- Load with r_resp = 2'b10 and out_ready_i held low for 4 cycles -> err_o = 1, wd_o = 0, outputs stable for 4 cycles, in_ready_o = 0 until one cycle after the output handshake.
- rstn = 0 in ADDR with ar_valid_o high -> next cycle ar_valid_o = 0, state IDLE, in_ready_o = 1, out_valid_o = 0.
